// File: rtl/id_ex_pkg.sv
// Shared widths, control/payload types and occupancy encoding for the ID/EX skid stage.
// The default-width types here describe the payload layout that id_ex_skid_stage mirrors with its own parameters.
package id_ex_pkg;

  localparam int ID_EX_DATA_W   = 32;
  localparam int ID_EX_ADDR_W   = 5;
  localparam int ID_EX_WB_W     = 2;
  localparam int ID_EX_MEM_W    = 2;
  localparam int ID_EX_ALU_OP_W = 2;
  localparam int ID_EX_CNT_W    = 16;

  typedef struct packed {
    logic [ID_EX_WB_W-1:0]     wb;
    logic [ID_EX_MEM_W-1:0]    mem;
    logic                      alu_src;
    logic [ID_EX_ALU_OP_W-1:0] alu_op;
    logic                      reg_dst;
  } id_ex_ctrl_t;

  typedef struct packed {
    id_ex_ctrl_t             ctrl;
    logic [ID_EX_DATA_W-1:0] rs_data;
    logic [ID_EX_DATA_W-1:0] rt_data;
    logic [ID_EX_DATA_W-1:0] imm;
    logic [ID_EX_ADDR_W-1:0] rs_addr;
    logic [ID_EX_ADDR_W-1:0] rt_addr;
    logic [ID_EX_ADDR_W-1:0] rd_addr;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/id_ex_sat_cnt.sv
// Saturating up-counter: advances by one on inc_i and sticks at all-ones; cleared only by rst_i.
module id_ex_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (inc_i && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubble clearing.
// Optional stall/bubble performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_skid_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W   = ID_EX_DATA_W,
  parameter int ADDR_W   = ID_EX_ADDR_W,
  parameter int WB_W     = ID_EX_WB_W,
  parameter int MEM_W    = ID_EX_MEM_W,
  parameter int ALU_OP_W = ID_EX_ALU_OP_W,
  parameter int CNT_W    = ID_EX_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WB_W-1:0]     wb_i,
  input  logic [MEM_W-1:0]    mem_i,
  input  logic                alu_src_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic                reg_dst_i,
  input  logic [DATA_W-1:0]   rs_data_i,
  input  logic [DATA_W-1:0]   rt_data_i,
  input  logic [DATA_W-1:0]   imm_i,
  input  logic [ADDR_W-1:0]   rs_addr_i,
  input  logic [ADDR_W-1:0]   rt_addr_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WB_W-1:0]     wb_o,
  output logic [MEM_W-1:0]    mem_o,
  output logic                alu_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                reg_dst_o,
  output logic [DATA_W-1:0]   rs_data_o,
  output logic [DATA_W-1:0]   rt_data_o,
  output logic [DATA_W-1:0]   imm_o,
  output logic [ADDR_W-1:0]   rs_addr_o,
  output logic [ADDR_W-1:0]   rt_addr_o,
  output logic [ADDR_W-1:0]   rd_addr_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
`endif
);

  // Same layout as id_ex_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [WB_W-1:0]     wb;
    logic [MEM_W-1:0]    mem;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_dst;
  } ctrl_t;

  typedef struct packed {
    ctrl_t               ctrl;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    logic [ADDR_W-1:0]   rs_addr;
    logic [ADDR_W-1:0]   rt_addr;
    logic [ADDR_W-1:0]   rd_addr;
  } payload_t;

  occ_e     occ_reg;
  occ_e     occ_next;
  payload_t main_reg;
  payload_t main_next;
  payload_t skid_reg;
  payload_t skid_next;
  payload_t in_pay;
  logic     acc;
  logic     drn;

  assign in_pay.ctrl.wb      = wb_i;
  assign in_pay.ctrl.mem     = mem_i;
  assign in_pay.ctrl.alu_src = alu_src_i;
  assign in_pay.ctrl.alu_op  = alu_op_i;
  assign in_pay.ctrl.reg_dst = reg_dst_i;
  assign in_pay.rs_data      = rs_data_i;
  assign in_pay.rt_data      = rt_data_i;
  assign in_pay.imm          = imm_i;
  assign in_pay.rs_addr      = rs_addr_i;
  assign in_pay.rt_addr      = rt_addr_i;
  assign in_pay.rd_addr      = rd_addr_i;

  // Ready depends only on registered occupancy, so there is no comb path from in_valid to ready.
  assign in_ready_o  = (occ_reg != TWO);
  assign out_valid_o = (occ_reg != EMPTY);
  assign acc         = in_valid_i & in_ready_o;
  assign drn         = out_valid_o & out_ready_i;

  always_comb begin
    occ_next  = occ_reg;
    main_next = main_reg;
    skid_next = skid_reg;
    if (flush_i) begin
      occ_next       = EMPTY;
      main_next.ctrl = '0;
    end else begin
      case (occ_reg)
        EMPTY: begin
          if (acc) begin
            main_next = in_pay;
            occ_next  = ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_next = in_pay;
          end else if (acc) begin
            skid_next = in_pay;
            occ_next  = TWO;
          end else if (drn) begin
            // Bubble: kill control so downstream never sees a stale write; data/addrs hold.
            main_next.ctrl = '0;
            occ_next       = EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            main_next = skid_reg;
            occ_next  = ONE;
          end
        end
        default: begin
          main_next.ctrl = '0;
          occ_next       = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_reg  <= EMPTY;
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      occ_reg  <= occ_next;
      main_reg <= main_next;
      skid_reg <= skid_next;
    end
  end

  assign wb_o      = main_reg.ctrl.wb;
  assign mem_o     = main_reg.ctrl.mem;
  assign alu_src_o = main_reg.ctrl.alu_src;
  assign alu_op_o  = main_reg.ctrl.alu_op;
  assign reg_dst_o = main_reg.ctrl.reg_dst;
  assign rs_data_o = main_reg.rs_data;
  assign rt_data_o = main_reg.rt_data;
  assign imm_o     = main_reg.imm;
  assign rs_addr_o = main_reg.rs_addr;
  assign rt_addr_o = main_reg.rt_addr;
  assign rd_addr_o = main_reg.rd_addr;

`ifdef ID_EX_PERF_EN
  id_ex_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

  id_ex_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~out_valid_o),
    .cnt_o (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench for id_ex_skid_stage: directed scenarios plus random traffic against a queue model.
// Define ID_EX_PERF_EN to build and check the performance counters (CNT_W=4).
module tb_id_ex_skid_stage;
  import id_ex_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [7:0]   ctrl;   // {wb, mem, alu_src, alu_op, reg_dst}
    logic [110:0] data;   // {rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr}
  } tb_instr_t;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  wb_i, mem_i, alu_op_i;
  logic        alu_src_i, reg_dst_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  wb_o, mem_o, alu_op_o;
  logic        alu_src_o, reg_dst_o;
  logic [31:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
`ifdef ID_EX_PERF_EN
  logic [TB_CNT_W-1:0] stall_cnt_o, bubble_cnt_o;
`endif

  tb_instr_t    in_instr;
  logic [7:0]   dut_ctrl;
  logic [110:0] dut_data;

  assign {wb_i, mem_i, alu_src_i, alu_op_i, reg_dst_i} = in_instr.ctrl;
  assign {rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i} = in_instr.data;
  assign dut_ctrl = {wb_o, mem_o, alu_src_o, alu_op_o, reg_dst_o};
  assign dut_data = {rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o};

  id_ex_skid_stage #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .WB_W     (2),
    .MEM_W    (2),
    .ALU_OP_W (2),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .wb_i        (wb_i),
    .mem_i       (mem_i),
    .alu_src_i   (alu_src_i),
    .alu_op_i    (alu_op_i),
    .reg_dst_i   (reg_dst_i),
    .rs_data_i   (rs_data_i),
    .rt_data_i   (rt_data_i),
    .imm_i       (imm_i),
    .rs_addr_i   (rs_addr_i),
    .rt_addr_i   (rt_addr_i),
    .rd_addr_i   (rd_addr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .wb_o        (wb_o),
    .mem_o       (mem_o),
    .alu_src_o   (alu_src_o),
    .alu_op_o    (alu_op_o),
    .reg_dst_o   (reg_dst_o),
    .rs_data_o   (rs_data_o),
    .rt_data_o   (rt_data_o),
    .imm_o       (imm_o),
    .rs_addr_o   (rs_addr_o),
    .rt_addr_o   (rt_addr_o),
    .rd_addr_o   (rd_addr_o)
`ifdef ID_EX_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-order queue of at most two accepted instructions.
  tb_instr_t q[$];
  tb_instr_t last_main;
  int        stall_m;
  int        bubble_m;
  int        n_cmp;
  int        n_bad;
  int        n_xfer;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tb_instr_t rand_instr();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return tb_instr_t'(r[$bits(tb_instr_t)-1:0]);
  endfunction

  task automatic compare_all();
    logic [7:0]   exp_ctrl;
    logic [110:0] exp_data;
    exp_ctrl = (q.size() != 0) ? q[0].ctrl : 8'h00;
    exp_data = (q.size() != 0) ? q[0].data : last_main.data;
    check("out_valid", 128'(out_valid_o), 128'(q.size() != 0));
    check("in_ready", 128'(in_ready_o), 128'(q.size() < 2));
    check("ctrl", 128'(dut_ctrl), 128'(exp_ctrl));
    check("data", 128'(dut_data), 128'(exp_data));
`ifdef ID_EX_PERF_EN
    check("stall_cnt", 128'(stall_cnt_o), 128'(stall_m));
    check("bubble_cnt", 128'(bubble_cnt_o), 128'(bubble_m));
`endif
  endtask

  // One clock: drive inputs, advance the model, clock the DUT, compare at the falling edge.
  task automatic step(input logic v, input logic ordy, input logic fl, input tb_instr_t p);
    bit m_valid;
    bit m_ready;
    bit acc;
    bit drn;
    in_valid_i  = v;
    out_ready_i = ordy;
    flush_i     = fl;
    in_instr    = p;
    m_valid = (q.size() != 0);
    m_ready = (q.size() < 2);
    acc = v && m_ready;
    drn = m_valid && ordy;
    if (rst_i) begin
      q.delete();
      last_main = '0;
      stall_m   = 0;
      bubble_m  = 0;
    end else begin
      if (m_valid && !ordy && stall_m < CNT_MAX) stall_m++;
      if (!m_valid && bubble_m < CNT_MAX) bubble_m++;
      if (drn) begin
        $display("xfer %0d: ctrl=%02h rs_data=%08h rd_addr=%0d", n_xfer, q[0].ctrl,
                 q[0].data[110:79], q[0].data[4:0]);
        n_xfer++;
      end
      if (fl) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(p);
      end
      if (q.size() != 0) last_main = q[0];
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  tb_instr_t s[8];
  tb_instr_t a, b, c;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_xfer = 0;
    last_main = '0;
    stall_m = 0;
    bubble_m = 0;
    in_instr = '0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    flush_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);

    // Reset: two cycles, then everything zero and ready high.
    step(1'b0, 1'b0, 1'b0, rand_instr());
    step(1'b1, 1'b1, 1'b0, rand_instr());
    check("rst_valid", 128'(out_valid_o), 128'(0));
    check("rst_ready", 128'(in_ready_o), 128'(1));
    check("rst_ctrl", 128'(dut_ctrl), 128'(0));
    check("rst_data", 128'(dut_data), 128'(0));
`ifdef ID_EX_PERF_EN
    check("rst_stall", 128'(stall_cnt_o), 128'(0));
    check("rst_bubble", 128'(bubble_cnt_o), 128'(0));
`endif
    rst_i = 1'b0;

    // Streaming: one instruction per cycle, each visible one cycle after acceptance.
    for (int i = 0; i < 8; i++) s[i] = rand_instr();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, s[i]);
      check("stream_valid", 128'(out_valid_o), 128'(1));
      check("stream_data", 128'(dut_data), 128'(s[i].data));
    end
    step(1'b0, 1'b1, 1'b0, rand_instr());

    // Skid: A and B arrive under backpressure, then drain back to back.
    a = rand_instr();
    b = rand_instr();
    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, b);
    check("skid_ready", 128'(in_ready_o), 128'(0));
    check("skid_hold_a", 128'(dut_data), 128'(a.data));
    step(1'b0, 1'b1, 1'b0, rand_instr());
    check("skid_b_next", 128'(dut_data), 128'(b.data));
    check("skid_ready_back", 128'(in_ready_o), 128'(1));
    step(1'b0, 1'b1, 1'b0, rand_instr());

    // Flush from full occupancy with a simultaneous input: everything is lost.
    a = rand_instr();
    b = rand_instr();
    c = rand_instr();
    c.ctrl[7:4] = 4'hF;
    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, b);
    step(1'b1, 1'b0, 1'b1, c);
    check("flush_valid", 128'(out_valid_o), 128'(0));
    check("flush_wb", 128'(wb_o), 128'(0));
    check("flush_mem", 128'(mem_o), 128'(0));
    step(1'b0, 1'b1, 1'b0, rand_instr());
    check("flush_lost", 128'(out_valid_o), 128'(0));

    // Bubble: a writeback instruction drains with nothing behind it.
    a = rand_instr();
    a.ctrl[7:6] = 2'b11;
    step(1'b1, 1'b1, 1'b0, a);
    step(1'b0, 1'b1, 1'b0, rand_instr());
    check("bubble_wb", 128'(wb_o), 128'(0));
    check("bubble_mem", 128'(mem_o), 128'(0));
    check("bubble_rs", 128'(rs_data_o), 128'(a.data[110:79]));

`ifdef ID_EX_PERF_EN
    // Stall counter saturates at all-ones and survives a flush.
    step(1'b1, 1'b0, 1'b0, rand_instr());
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, rand_instr());
    check("perf_stall_sat", 128'(stall_cnt_o), 128'(4'hF));
    step(1'b1, 1'b0, 1'b1, rand_instr());
    check("perf_flush_keep", 128'(stall_cnt_o), 128'(4'hF));
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0),
           1'($urandom_range(15, 0) == 0), rand_instr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
